uart_fifo: RTL and testbench

Parametrised synchronous FIFO used as the TX/RX holding buffer between the bus-side register interface and the UART shifters. It uses a register-array store with write-on-clock and asynchronous read, so it presents first-word-fall-through data. It adds full/empty status, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_fifo.sv | 116 +++++++++++
 tb/tb_uart_fifo.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared defaults and sizing helpers for the UART holding FIFOs.
package uart_pkg;

    localparam int UART_DATA_WIDTH      = 8;
    localparam int UART_FIFO_ADDR_WIDTH = 4;
    localparam int UART_FIFO_DEPTH      = 2**UART_FIFO_ADDR_WIDTH;

    function automatic int fifo_depth(input int addr_width);
        return 2**addr_width;
    endfunction

    // Pointers and the occupancy count carry one extra bit so full and empty differ.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array store: written on the clock edge, read asynchronously.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through holding FIFO with status thresholds, sticky error flags and flush.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int             CW        = cnt_width(ADDR_WIDTH);
    localparam int             DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]  ONE       = CW'(1);

    logic [CW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] wr_ptr_next, rd_ptr_next, count_next;
    logic          ovf_next, unf_next;
    logic          wr_acc, rd_acc;
    logic [31:0]   count_ext;

    // Handshake: wr_en/rd_en are requests sampled at the rising edge. A read is
    // accepted when the FIFO holds data; a write is accepted when there is room
    // or a read frees a slot in the same edge. Rejected requests only set the
    // sticky error flags. clr overrides both requests.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        ovf_next    = overflow;
        unf_next    = underflow;
        if (clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            ovf_next    = 1'b0;
            unf_next    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_next = wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr_next = rd_ptr + ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_next = count + ONE;
                2'b01:   count_next = count - ONE;
                default: count_next = count;
            endcase
            if (wr_en & full & ~rd_acc) begin
                ovf_next = 1'b1;
            end
            if (rd_en & empty) begin
                unf_next = 1'b1;
            end
        end
    end

    // Thresholds compare in 32 bits so any ADDR_WIDTH elaborates cleanly.
    assign count_ext = 32'(count_next);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_CNT);
            almost_empty <= (count_ext <= 32'(AE_LEVEL));
            almost_full  <= (count_ext >= 32'(AF_LEVEL));
            overflow     <= ovf_next;
            underflow    <= unf_next;
        end
    end

    uart_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~clr),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: scoreboard queue of expected read data plus status checks.
module tb_uart_fifo;

    logic       clk;
    logic       reset_n;
    logic       clr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    uart_fifo dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: called at edge+1, holds inputs across one edge, returns at edge+1
    task automatic cycle(input logic w, input logic [7:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic flush();
        clr = 1'b1;
        cycle(1'b1, 8'h77, 1'b1);
        clr = 1'b0;
    endtask

    // monitor: a read accepted at the coming edge pops the scoreboard
    always @(negedge clk) begin
        if (reset_n && !clr && rd_en && !empty) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: got 0x%0h with nothing expected at %0t", rd_data, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL read_data: got 0x%0h expected 0x%0h at %0t", rd_data, e, $time);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);

        // fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            exp_q.push_back(8'(i));
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_almost_full", 32'(almost_full), 32'((i + 1) >= 14));
            check("fill_almost_empty", 32'(almost_empty), 32'((i + 1) <= 2));
            check("fill_full", 32'(full), 32'((i + 1) == 16));
        end

        // write while full is dropped
        cycle(1'b1, 8'hAA, 1'b0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_full", 32'(full), 32'd1);

        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            check("drain_count", 32'(count), 32'(15 - i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_almost_empty", 32'(almost_empty), 32'd1);

        cycle(1'b0, 8'h00, 1'b1);
        check("unf_flag", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        flush();
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_underflow", 32'(underflow), 32'd0);
        check("clr_empty", 32'(empty), 32'd1);
        check("clr_count", 32'(count), 32'd0);

        // simultaneous read/write at count 5 across the pointer wrap
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 1'b0);
            exp_q.push_back(8'(8'h10 + i));
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(8'h20 + i), 1'b1);
            exp_q.push_back(8'(8'h20 + i));
            check("sim_count", 32'(count), 32'd5);
        end
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, 8'(8'h40 + i), 1'b0);
            exp_q.push_back(8'(8'h40 + i));
        end
        check("refill_full", 32'(full), 32'd1);

        cycle(1'b1, 8'h99, 1'b1);
        exp_q.push_back(8'h99);
        check("full_rw_full", 32'(full), 32'd1);
        check("full_rw_overflow", 32'(overflow), 32'd0);
        check("full_rw_count", 32'(count), 32'd16);

        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
        end
        check("drain2_empty", 32'(empty), 32'd1);

        // write+read on empty: write only, no bypass
        cycle(1'b1, 8'h5C, 1'b1);
        exp_q.push_back(8'h5C);
        check("empty_rw_count", 32'(count), 32'd1);
        check("empty_rw_underflow", 32'(underflow), 32'd1);
        check("empty_rw_data", 32'(rd_data), 32'h5C);
        cycle(1'b0, 8'h00, 1'b1);
        flush();

        // asynchronous reset mid-fill
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 8'(8'h60 + i), 1'b0);
            exp_q.push_back(8'(8'h60 + i));
        end
        check("pre_rst_count", 32'(count), 32'd7);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_empty", 32'(empty), 32'd1);
        exp_q.delete();
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h33, 1'b0);
        exp_q.push_back(8'h33);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_data", 32'(rd_data), 32'h33);
        cycle(1'b0, 8'h00, 1'b1);
        check("post_rst_empty", 32'(empty), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
